// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared types and constants for the PS/2 host transmitter.
//   ps2_tx_state_t : FSM states of the host-to-device frame sequencer
//   PS2_CMD_*      : common host command bytes
//   odd_parity()   : PS/2 parity bit for a data byte (odd parity over 9 bits)
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and status between a requester and ps2_host_tx.
//   tx_data/tx_valid  : requester -> transmitter, accepted when tx_valid && tx_ready
//   tx_ready          : transmitter idle
//   tx_active         : frame in flight (receive path should ignore the line)
//   done/ack_ok       : end-of-frame pulse and device ACK status
//   err_timeout       : watchdog abort pulse
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_active;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_active, done, ack_ok, err_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_active, done, ack_ok, err_timeout
    );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pad level.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous pad level
//   level    : synchronised, debounced level; changes only after FILTER_LEN
//              consecutive synced samples disagree with it. Presets to 1 (idle line).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            // cnt counts consecutive samples that disagree with the current level
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (one command byte per request).
//   clk, rst        : game clock, synchronous active-high reset
//   bus (slave)     : tx_data/tx_valid/tx_ready handshake, tx_active, done, ack_ok, err_timeout
//   ps2_clk_in      : raw PS2_CLK pad level
//   ps2_data_in     : raw PS2_DATA pad level
//   ps2_clk_oe      : 1 = pull PS2_CLK low
//   ps2_data_oe     : 1 = pull PS2_DATA low
// Sequence: inhibit clock, request-to-send (start bit), shift D0..D7, parity and
// stop on device clock falls, sample ACK, wait for an idle line.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2750,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 8
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_tx_if.slave   bus,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t    state;
    logic [7:0]       shreg;
    logic             parity;
    logic [3:0]       bitcnt;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wdog;
    logic             done_q, err_q, ack_q;

    logic clk_f, data_f, clk_f_q, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .raw(ps2_clk_in), .level(clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .rst(rst), .raw(ps2_data_in), .level(data_f)
    );

    always_ff @(posedge clk) begin
        if (rst) clk_f_q <= 1'b1;
        else     clk_f_q <= clk_f;
    end

    // Both operands are registers, so this is a clean one-cycle pulse
    assign fall = clk_f_q & ~clk_f;

    assign bus.tx_ready    = (state == ST_IDLE);
    assign bus.tx_active   = (state != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.err_timeout = err_q;
    assign bus.ack_ok      = ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            shreg       <= '0;
            parity      <= 1'b0;
            bitcnt      <= '0;
            inh_cnt     <= '0;
            wdog        <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.tx_valid) begin
                        shreg       <= bus.tx_data;
                        parity      <= odd_parity(bus.tx_data);
                        ack_q       <= 1'b0;
                        inh_cnt     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    // start bit goes low one cycle before the clock is released
                    if (inh_cnt == INH_PRE) ps2_data_oe <= 1'b1;
                    if (inh_cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        wdog       <= '0;
                        bitcnt     <= '0;
                        state      <= ST_REQ;
                    end
                end
                default: begin
                    // REQ/SEND/ACK/WAIT_IDLE: device-clocked, guarded by the watchdog.
                    // Timeout is checked first so it wins over a coincident fall.
                    if (wdog == WD_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        ack_q       <= 1'b0;
                        err_q       <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= fall ? '0 : wdog + 1'b1;
                        case (state)
                            ST_REQ, ST_SEND: begin
                                if (fall) begin
                                    bitcnt <= bitcnt + 1'b1;
                                    state  <= (bitcnt == 4'd9) ? ST_ACK : ST_SEND;
                                    if (bitcnt < 4'd8)       ps2_data_oe <= ~shreg[bitcnt[2:0]];
                                    else if (bitcnt == 4'd8) ps2_data_oe <= ~parity;
                                    else                     ps2_data_oe <= 1'b0;
                                end
                            end
                            ST_ACK: begin
                                if (fall) begin
                                    ack_q <= ~data_f;
                                    state <= ST_WAIT_IDLE;
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clk_f && data_f) begin
                                    done_q <= 1'b1;
                                    state  <= ST_IDLE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model
// (open-drain pads, half-period HALF cycles).
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    int n_chk = 0, n_fail = 0;

    // event monitor
    int cyc = 0, done_cnt = 0, err_cnt = 0, clk_oe_cyc = 0, overlap_cyc = 0;
    int req_cyc = 0, err_cyc = 0;
    logic clk_oe_q = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err_timeout) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (ps2_clk_oe) clk_oe_cyc <= clk_oe_cyc + 1;
        if (ps2_clk_oe && ps2_data_oe) overlap_cyc <= overlap_cyc + 1;
        if (clk_oe_q && !ps2_clk_oe && ps2_data_oe) req_cyc <= cyc;
        clk_oe_q <= ps2_clk_oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request a byte and play the device side. Returns early (device clock held low)
    // after max_falls falls; max_falls=0 returns once request-to-send is seen.
    task automatic run_frame(input logic [7:0] d, input bit ack, input bit disturb,
                             input int max_falls, output logic [10:0] bits, output bit reached);
        int n;
        bits    = '0;
        reached = 1'b0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) return;
        reached = 1'b1;
        bits[0] = ps2_data_in;
        if (max_falls == 0) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            if (k == max_falls) return;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k] = ps2_data_in;
            if (disturb && k == 5) begin
                repeat (5) @(negedge clk);
                glitch       = 1'b1;
                bus.tx_data  = 8'h00;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                repeat (2) @(negedge clk);
                glitch = 1'b0;
                repeat (HALF/2 - 8) @(negedge clk);
            end else begin
                repeat (HALF/2) @(negedge clk);
            end
            if (k == 10 && ack) dev_data_low = 1'b1;
            repeat (HALF/2) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF/2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        bit          disturb;
        logic [10:0] bits;     // {stop, parity, D7..D0, start}
        logic        ack_ok;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [10:0] bits;
        bit reached;
        int d0, e0, c0, o0, n;

        vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b0, 11'b1_1_11101101_0, 1'b1};
        vecs[1] = '{8'h01,            1'b1, 1'b0, 11'b1_0_00000001_0, 1'b1};
        vecs[2] = '{PS2_CMD_RESET,    1'b0, 1'b0, 11'b1_1_11111111_0, 1'b0};
        vecs[3] = '{8'hA5,            1'b1, 1'b0, 11'b1_1_10100101_0, 1'b1};
        vecs[4] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b1, 11'b1_1_11101101_0, 1'b1};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ps2_clk_oe, ps2_data_oe, bus.done, bus.err_timeout, bus.ack_ok, bus.tx_ready, bus.tx_active},
              7'b0000010);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt; e0 = err_cnt; c0 = clk_oe_cyc; o0 = overlap_cyc;
            run_frame(vecs[i].data, vecs[i].ack, vecs[i].disturb, 99, bits, reached);
            check($sformatf("v%0d_req_seen", i), reached, 1);
            n = 0;
            while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_bits", i), bits, vecs[i].bits);
            check($sformatf("v%0d_done_pulses", i), done_cnt - d0, 1);
            check($sformatf("v%0d_err_pulses", i), err_cnt - e0, 0);
            check($sformatf("v%0d_ack_ok", i), bus.ack_ok, vecs[i].ack_ok);
            check($sformatf("v%0d_tx_ready", i), {bus.tx_ready, bus.tx_active}, 2'b10);
            check($sformatf("v%0d_inhibit_len", i), clk_oe_cyc - c0, INH);
            check($sformatf("v%0d_start_overlap", i), overlap_cyc - o0, 1);
            if (vecs[i].disturb) begin
                c0 = clk_oe_cyc;
                repeat (100) @(negedge clk);
                check("midframe_valid_not_queued", clk_oe_cyc - c0, 0);
            end
        end

        // device never clocks: watchdog abort
        d0 = done_cnt; e0 = err_cnt;
        run_frame(8'h3C, 1'b1, 1'b0, 0, bits, reached);
        check("tmo_req_seen", reached, 1);
        n = 0;
        while (err_cnt == e0 && n < TMO + 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("tmo_latency", err_cyc - req_cyc, TMO);
        check("tmo_err_pulses", err_cnt - e0, 1);
        check("tmo_no_done", done_cnt - d0, 0);
        check("tmo_pads_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("tmo_ack_ok", bus.ack_ok, 1'b0);
        check("tmo_tx_ready", bus.tx_ready, 1'b1);

        // reset after the 4th device fall
        d0 = done_cnt; e0 = err_cnt;
        run_frame(8'h00, 1'b1, 1'b0, 4, bits, reached);
        repeat (20) @(negedge clk);
        check("rst_pre_data_oe", ps2_data_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pads_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_err", err_cnt - e0, 0);

        // recovery frame after reset
        d0 = done_cnt;
        run_frame(8'h01, 1'b1, 1'b0, 99, bits, reached);
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("recover_bits", bits, 11'b1_0_00000001_0);
        check("recover_done", done_cnt - d0, 1);
        check("recover_ack_ok", bus.ack_ok, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
